eth_nios_v2_irq_pio_multi: RTL
==============================

Name: eth_nios_v2_irq_pio_multi

Overview:
Parametrised successor of the single-bit Ethernet IRQ PIO. It monitors WIDTH asynchronous interrupt lines from the Ethernet MAC/PHY side, with these per-channel features:
- configurable synchronisation depth;
- optional glitch filter;
- programmable edge sense;
- write-1-to-clear capture;
- software force-set.
It presents them to the Nios II as one Avalon-MM slave with a single registered, level-sensitive irq.

Parameters:
WIDTH, 4, number of input channels (1..16).
SYNC_STAGES, 2, synchroniser flops per channel (2..4).
FILTER_CYCLES, 0, consecutive cycles a changed synced level must persist before acceptance; 0 = bypass.
CNT_W, 4, filter counter width; must satisfy 2^CNT_W > FILTER_CYCLES.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
address  in  3  Avalon word address
chipselect  in  1  Avalon slave select
write_n  in  1  Avalon write strobe, active low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, read latency 1
in_port  in  WIDTH  asynchronous interrupt sources
irq  out  1  interrupt request to CPU, active high

Behaviour:
Interface: one clock; reset is synchronous and active-high (ports clk, reset).

Reset
- All registers are cleared on the cycle reset is high: sync chains, filt, filt_d, filter counters, mode, mask, capture, readdata and irq.
- Reset mid-operation discards pending captures immediately.

Register map (wr = chipselect & ~write_n; bits >= WIDTH read 0, writes ignored there)
- 0 DATA (RO): filt[WIDTH-1:0].
- 1 MODE (RW): 2 bits per channel n at [2n+1:2n]. 00 = off, 01 = rising, 10 = falling, 11 = both.
- 2 MASK (RW): per-channel irq enable.
- 3 CAPTURE (R/W1C): writing 1 clears that bit.
- 4 PENDING (RO): capture & mask.
- 5 FORCE (WO, reads 0): writing 1 sets the capture bit; used for software test.
- 6, 7: read 0, writes ignored.

Read path
- readdata is registered every cycle from the current address, independent of chipselect.
- Value is valid on the edge after address is presented.

Input pipeline, per channel
- Synchroniser: SYNC_STAGES flops feed sync_out.
- Filter bypass (FILTER_CYCLES = 0): filt <= sync_out every cycle.
- Filter enabled:
  - If sync_out == filt, the counter is cleared.
  - Otherwise the counter increments.
  - When the counter == FILTER_CYCLES-1 and the mismatch persists, filt <= sync_out and the counter clears.
  - Any return to agreement before that point clears the counter; the glitch is rejected.
- filt_d <= filt every cycle.

Edge detection
- rise = filt & ~filt_d; fall = ~filt & filt_d.
- edge_n = (mode[0] & rise) | (mode[1] & fall).

Post-reset arm
- An arm counter runs for SYNC_STAGES+FILTER_CYCLES+2 cycles after reset deasserts.
- Until it expires, edge_n is forced to 0. Inputs already high at reset release therefore produce no capture.

Capture update, priority order
- edge_n sets the bit; this wins over a simultaneous W1C, so no event is lost.
- A FORCE write sets the bit.
- A W1C write clears the bit.
- Otherwise the bit holds.

MODE and MASK changes
- Changing MODE never creates an edge; filt and filt_d are unaffected.
- Changing MASK affects irq on the next cycle without altering capture.

Interrupt output
- irq <= |(capture & mask), registered.
- It stays asserted until every masked pending bit is cleared or masked.

Latency (armed, FILTER_CYCLES = F)
- in_port transition to capture bit set: SYNC_STAGES + max(F,1) + 1 edges.
- irq asserts one edge later.

Test Plan:
1. WIDTH=4, SYNC_STAGES=2, F=0, MODE=0x01, MASK=0x1. in_port[0] 0->1 after arm → capture=0x1 at edge 4, irq=1 at edge 5. Write 0x1 to addr 3 → irq=0 two edges later.
2. MODE=0x0A (ch1 falling only), ch1 pulses 1->0->1 with 10-cycle holds → capture=0x2 only after the fall; the rise sets nothing. MODE=0x0F: both edges capture.
3. F=3: 2-cycle glitch on ch2 → no capture, DATA unchanged. 5-cycle pulse → DATA[2] rises 3 cycles after sync, capture[2]=1.
4. Same-cycle edge on ch0 and W1C write of 0x1 to addr 3 → capture[0] stays 1. Write 0x4 to addr 5 → capture=0x5, PENDING=capture&MASK.
5. in_port=0xF held through reset release → capture=0, irq=0 after arm. Assert reset with capture=0xF, irq=1 → both 0 on the next edge.
6. Read addr 6/7 → 0. Write 0xFFFFFFFF to MASK with WIDTH=4 → MASK reads 0x0000000F.

Source files
------------

// File: rtl/eth_nios_v2_irq_pio_multi_if.sv
// Avalon-MM slave bus bundle for the multi-channel Ethernet IRQ PIO.
// Latency: none (wires only); readdata is registered inside the slave.
// Backpressure: none, the slave is always ready (no waitrequest).
// Signals: address[2:0], chipselect, write_n (active low), writedata[31:0],
// readdata[31:0] (read latency 1).
interface eth_nios_v2_irq_pio_multi_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/eth_nios_v2_irq_pio_multi.sv
// WIDTH-channel async IRQ monitor: sync, optional glitch filter, edge sense, W1C capture, registered irq.
// Latency: in_port edge to capture = SYNC_STAGES + max(FILTER_CYCLES,1) + 1 clocks, irq one clock later.
// Backpressure: none; Avalon slave always accepts, readdata valid one clock after address.
// Ports: clk, reset (sync, active high), avs (Avalon-MM slave bundle),
//        in_port[WIDTH-1:0] (async sources), irq (level, active high).
module eth_nios_v2_irq_pio_multi #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0,
  parameter int CNT_W         = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  eth_nios_v2_irq_pio_multi_if.slave      avs,
  input  logic [WIDTH-1:0]                in_port,
  output logic                            irq
);

  localparam int ARM_CYCLES = SYNC_STAGES + FILTER_CYCLES + 2;
  localparam int ARM_W      = $clog2(ARM_CYCLES + 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]   sync_out;
  logic [WIDTH-1:0]   filt;
  logic [WIDTH-1:0]   filt_d;
  logic [2*WIDTH-1:0] mode;
  logic [WIDTH-1:0]   mask;
  logic [WIDTH-1:0]   capture;
  logic [WIDTH-1:0]   capture_nxt;
  logic [WIDTH-1:0]   rise;
  logic [WIDTH-1:0]   fall;
  logic [WIDTH-1:0]   edge_v;
  logic [ARM_W-1:0]   arm_cnt;
  logic               armed;
  logic               wr;
  logic               wr_mode;
  logic               wr_mask;
  logic               wr_cap;
  logic               wr_force;
  logic [31:0]        rd_mux;
  logic               unused_wdata;

  // Upper writedata bits are not backed by storage for small WIDTH.
  assign unused_wdata = ^avs.writedata;

  assign wr       = avs.chipselect & ~avs.write_n;
  assign wr_mode  = wr && (avs.address == 3'd1);
  assign wr_mask  = wr && (avs.address == 3'd2);
  assign wr_cap   = wr && (avs.address == 3'd3);
  assign wr_force = wr && (avs.address == 3'd5);

  // Synchroniser: in_port enters at index 0, oldest sample at the top.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
  end
  assign sync_out = sync_q[SYNC_STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk) begin
        if (reset) filt <= '0;
        else       filt <= sync_out;
      end
    end else begin : g_filter
      localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_CYCLES - 1);
      logic [CNT_W-1:0] cnt [WIDTH];

      // A new level is accepted only after FILTER_CYCLES consecutive
      // disagreeing samples; any agreement restarts the count.
      always_ff @(posedge clk) begin
        if (reset) begin
          filt <= '0;
          for (int n = 0; n < WIDTH; n++) cnt[n] <= '0;
        end else begin
          for (int n = 0; n < WIDTH; n++) begin
            if (sync_out[n] == filt[n]) begin
              cnt[n] <= '0;
            end else if (cnt[n] == FILT_LAST) begin
              filt[n] <= sync_out[n];
              cnt[n]  <= '0;
            end else begin
              cnt[n] <= cnt[n] + 1'b1;
            end
          end
        end
      end
    end
  endgenerate

  // Arm counter hides the pipeline fill after reset so lines already high
  // at release do not look like rising edges.
  assign armed = (arm_cnt == ARM_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_d  <= '0;
      arm_cnt <= '0;
    end else begin
      filt_d <= filt;
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
    end
  end

  assign rise = filt & ~filt_d;
  assign fall = ~filt & filt_d;

  always_comb begin
    edge_v = '0;
    for (int n = 0; n < WIDTH; n++) begin
      edge_v[n] = armed & ((mode[2*n] & rise[n]) | (mode[2*n+1] & fall[n]));
    end
  end

  // Applied lowest priority first so a same-cycle edge overrides a W1C.
  always_comb begin
    capture_nxt = capture;
    if (wr_cap)   capture_nxt = capture_nxt & ~avs.writedata[WIDTH-1:0];
    if (wr_force) capture_nxt = capture_nxt | avs.writedata[WIDTH-1:0];
    capture_nxt = capture_nxt | edge_v;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode    <= '0;
      mask    <= '0;
      capture <= '0;
      irq     <= 1'b0;
    end else begin
      if (wr_mode) mode <= avs.writedata[2*WIDTH-1:0];
      if (wr_mask) mask <= avs.writedata[WIDTH-1:0];
      capture <= capture_nxt;
      irq     <= |(capture & mask);
    end
  end

  // Read mux is decoded from address alone; chipselect is not required.
  always_comb begin
    rd_mux = '0;
    case (avs.address)
      3'd0:    rd_mux[WIDTH-1:0]   = filt;
      3'd1:    rd_mux[2*WIDTH-1:0] = mode;
      3'd2:    rd_mux[WIDTH-1:0]   = mask;
      3'd3:    rd_mux[WIDTH-1:0]   = capture;
      3'd4:    rd_mux[WIDTH-1:0]   = capture & mask;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) avs.readdata <= '0;
    else       avs.readdata <= rd_mux;
  end

endmodule
